// File: rtl/vx_alu_pe_sequencer.sv
// vx_alu_pe_sequencer: steers execute requests to PE_COUNT processing elements and returns
// their results strictly in issue order. Optional perf counters enabled by VX_PE_SEQ_PERF_EN.
module vx_alu_pe_sequencer #(
    parameter int PE_COUNT = 3,
    parameter int DATA_W   = 64,
    parameter int RES_W    = 64,
    parameter int DEPTH    = 4,
    localparam int SEL_W   = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_W-1:0]          req_pe_sel,
    input  logic [DATA_W-1:0]         req_data,
    output logic [PE_COUNT-1:0]       pe_req_valid,
    input  logic [PE_COUNT-1:0]       pe_req_ready,
    output logic [DATA_W-1:0]         pe_req_data,
    input  logic [PE_COUNT-1:0]       pe_rsp_valid,
    output logic [PE_COUNT-1:0]       pe_rsp_ready,
    input  logic [PE_COUNT*RES_W-1:0] pe_rsp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RES_W-1:0]          rsp_data,
    output logic [SEL_W-1:0]          rsp_pe_sel,
`ifdef VX_PE_SEQ_PERF_EN
    output logic [31:0]               perf_issue_cnt,
    output logic [31:0]               perf_stall_cnt,
`endif
    output logic                      busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SEL_W-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rsp_valid;
    logic [RES_W-1:0] r_rsp_data;
    logic [SEL_W-1:0] r_rsp_pe_sel;

    logic [SEL_W-1:0] w_esel;
    logic [SEL_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_sel_ready;
    logic             w_push;
    logic             w_can_load;
    logic             w_head_valid;
    logic             w_pop;
    logic [RES_W-1:0] w_head_data;

    // Out-of-range selects fall back to PE0 so a bad index can never wedge the block.
    assign w_esel  = ({1'b0, req_pe_sel} < (SEL_W+1)'(PE_COUNT)) ? req_pe_sel : '0;
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];

    always_comb begin
        w_sel_ready  = 1'b0;
        pe_req_valid = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (SEL_W'(i) == w_esel) begin
                w_sel_ready     = pe_req_ready[i];
                pe_req_valid[i] = req_valid & ~w_full;
            end
        end
    end

    assign req_ready   = w_sel_ready & ~w_full;
    assign pe_req_data = req_data;
    assign w_push      = req_valid & req_ready;

    // Only the oldest outstanding PE may hand over a result, and only if the output slot frees.
    assign w_can_load = ~w_empty & (~r_rsp_valid | rsp_ready);

    always_comb begin
        w_head_valid = 1'b0;
        w_head_data  = '0;
        pe_rsp_ready = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (SEL_W'(i) == w_head) begin
                w_head_valid    = pe_rsp_valid[i];
                w_head_data     = pe_rsp_data[i*RES_W +: RES_W];
                pe_rsp_ready[i] = w_can_load;
            end
        end
    end

    assign w_pop = w_can_load & w_head_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_esel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_pe_sel <= '0;
        end else if (w_pop) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= w_head_data;
            r_rsp_pe_sel <= w_head;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_pe_sel = r_rsp_pe_sel;
    assign busy       = ~w_empty | r_rsp_valid;

`ifdef VX_PE_SEQ_PERF_EN
    logic [31:0] r_perf_issue_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_issue_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
            end
            if (req_valid && !req_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
